key_debounce: RTL and testbench



---
 rtl/key_debounce.sv | 111 +++++++++++
 tb/tb_key_debounce.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - per-key synchroniser, bounce filter and press/release strobes
//
// Purpose:
//   Conditions raw active-low push-buttons for downstream logic.
//   Each key passes through a 2-flop synchroniser and a stability counter.
//   A new level is accepted only after DEBOUNCE_CYCLES consecutive edges disagree
//   with the current debounced level.
//   KEY_STATE keeps the raw polarity (0 = pressed).
//
// Ports:
//   CLOCK_50    in   1       system clock, rising edge
//   RESET_N     in   1       asynchronous active-low reset
//   KEY         in   N_KEYS  raw push-buttons, active-low
//   KEY_STATE   out  N_KEYS  debounced level, active-low, registered
//   KEY_PRESS   out  N_KEYS  one-cycle strobe on accepted 1->0
//   KEY_RELEASE out  N_KEYS  one-cycle strobe on accepted 0->1
//   KEY_TOGGLE  out  N_KEYS  (only with KEY_TOGGLE_EN) flips on every accepted press
//
// Build option:
//   KEY_TOGGLE_EN - adds the KEY_TOGGLE output and its flops.

module key_debounce #(
   parameter int N_KEYS          = 2,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic              CLOCK_50,
   input  logic              RESET_N,
   input  logic [N_KEYS-1:0] KEY,
   output logic [N_KEYS-1:0] KEY_STATE,
   output logic [N_KEYS-1:0] KEY_PRESS,
   output logic [N_KEYS-1:0] KEY_RELEASE
`ifdef KEY_TOGGLE_EN
   ,
   output logic [N_KEYS-1:0] KEY_TOGGLE
`endif
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [N_KEYS-1:0]            sync1_q,   sync1_d;
   logic [N_KEYS-1:0]            sync2_q,   sync2_d;
   logic [N_KEYS-1:0]            state_q,   state_d;
   logic [N_KEYS-1:0]            press_q,   press_d;
   logic [N_KEYS-1:0]            release_q, release_d;
   logic [N_KEYS-1:0][CNT_W-1:0] cnt_q,     cnt_d;
`ifdef KEY_TOGGLE_EN
   logic [N_KEYS-1:0]            toggle_q,  toggle_d;
`endif

   always_comb begin
      sync1_d   = KEY;
      sync2_d   = sync1_q;
      state_d   = state_q;
      press_d   = '0;
      release_d = '0;
      cnt_d     = '0;
      for (int i = 0; i < N_KEYS; i++) begin
         // Agreement with the debounced level leaves cnt_d at zero, which is
         // what rejects any bounce shorter than DEBOUNCE_CYCLES edges.
         if (sync2_q[i] != state_q[i]) begin
            // >= rather than == keeps the counter from ever wrapping.
            if (cnt_q[i] >= CNT_MAX) begin
               state_d[i]   = sync2_q[i];
               press_d[i]   = ~sync2_q[i];
               release_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

`ifdef KEY_TOGGLE_EN
   always_comb begin
      toggle_d = toggle_q ^ press_d;
   end
`endif

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         sync1_q   <= '1;
         sync2_q   <= '1;
         state_q   <= '1;
         press_q   <= '0;
         release_q <= '0;
         cnt_q     <= '0;
`ifdef KEY_TOGGLE_EN
         toggle_q  <= '0;
`endif
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         state_q   <= state_d;
         press_q   <= press_d;
         release_q <= release_d;
         cnt_q     <= cnt_d;
`ifdef KEY_TOGGLE_EN
         toggle_q  <= toggle_d;
`endif
      end
   end

   assign KEY_STATE   = state_q;
   assign KEY_PRESS   = press_q;
   assign KEY_RELEASE = release_q;
`ifdef KEY_TOGGLE_EN
   assign KEY_TOGGLE  = toggle_q;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - self-checking bench for key_debounce

module tb_key_debounce;

   localparam int N  = 2;
   localparam int D  = 4;
   localparam int CW = 3;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b1;
   logic [N-1:0] key   = '1;
   logic [N-1:0] key_state, key_press, key_release;
`ifdef KEY_TOGGLE_EN
   logic [N-1:0] key_toggle;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: a key flips once the last D filter inputs (raw samples
   // delayed by two edges) all disagree with the debounced level.
   logic [N-1:0] m_pa, m_pb, m_state, m_press, m_release;
`ifdef KEY_TOGGLE_EN
   logic [N-1:0] m_toggle;
`endif
   logic [N-1:0] m_win[$];

   key_debounce #(.N_KEYS(N), .DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
      .CLOCK_50   (clk),
      .RESET_N    (rst_n),
      .KEY        (key),
      .KEY_STATE  (key_state),
      .KEY_PRESS  (key_press),
      .KEY_RELEASE(key_release)
`ifdef KEY_TOGGLE_EN
      ,
      .KEY_TOGGLE (key_toggle)
`endif
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      m_pa      = '1;
      m_pb      = '1;
      m_state   = '1;
      m_press   = '0;
      m_release = '0;
`ifdef KEY_TOGGLE_EN
      m_toggle  = '0;
`endif
      m_win.delete();
      for (int j = 0; j < D; j++) m_win.push_back('1);
   endfunction

   // One rising edge; advances the model and returns 1 time unit after the edge.
   task automatic tick();
      logic [N-1:0] f;
      logic         all_diff;
      @(posedge clk);
      f    = m_pb;
      m_pb = m_pa;
      m_pa = key;
      m_win.push_back(f);
      if (m_win.size() > D) void'(m_win.pop_front());
      m_press   = '0;
      m_release = '0;
      for (int i = 0; i < N; i++) begin
         all_diff = 1'b1;
         foreach (m_win[j]) if (m_win[j][i] == m_state[i]) all_diff = 1'b0;
         if (all_diff) begin
            m_state[i] = ~m_state[i];
            if (m_state[i] == 1'b0) begin
               m_press[i] = 1'b1;
`ifdef KEY_TOGGLE_EN
               m_toggle[i] = ~m_toggle[i];
`endif
            end else begin
               m_release[i] = 1'b1;
            end
         end
      end
      #1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      key   = 2'b11;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (key_state !== 2'b11 || key_press !== 2'b00 || key_release !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_async: state=%b press=%b release=%b, required 11/00/00", key_state, key_press, key_release);
      end
`ifdef KEY_TOGGLE_EN
      n_tests++;
      if (key_toggle !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_toggle: toggle=%b, required 00", key_toggle);
      end
`endif
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         tick();
         n_tests++;
         if (key_state !== 2'b11 || key_press !== 2'b00 || key_release !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_hold edge %0d: state=%b press=%b release=%b, required 11/00/00", e, key_state, key_press, key_release);
         end
      end
   endtask

   task automatic test_press();
      logic [N-1:0] exp_state, exp_press;
      apply_reset();
      key = 2'b10;
      for (int e = 1; e <= 7; e++) begin
         tick();
         exp_state = (e >= 6) ? 2'b10 : 2'b11;
         exp_press = (e == 6) ? 2'b01 : 2'b00;
         n_tests++;
         if (key_state !== exp_state || key_press !== exp_press || key_release !== 2'b00) begin
            n_fail++;
            $display("FAIL press edge %0d: state=%b press=%b release=%b, required %b/%b/00", e, key_state, key_press, key_release, exp_state, exp_press);
         end
      end
   endtask

   task automatic test_bounce();
      apply_reset();
      key = 2'b11;
      for (int e = 1; e <= 16; e++) begin
         key = (e >= 3 && e <= 5) ? 2'b10 : 2'b11;
         tick();
         n_tests++;
         if (key_state !== 2'b11 || key_press !== 2'b00 || key_release !== 2'b00) begin
            n_fail++;
            $display("FAIL bounce edge %0d: state=%b press=%b release=%b, required 11/00/00", e, key_state, key_press, key_release);
         end
      end
   endtask

   task automatic test_alternate();
      int n_press  = 0;
      int at_edge  = -1;
      apply_reset();
      for (int e = 1; e <= 22; e++) begin
         key = (e <= 10 && (e % 2 == 0)) ? 2'b11 : 2'b10;
         tick();
         if (key_press[0] === 1'b1) begin
            n_press++;
            at_edge = e;
         end
         n_tests++;
         if (key_press !== m_press || key_state !== m_state) begin
            n_fail++;
            $display("FAIL alternate_model edge %0d: state=%b press=%b, required %b/%b", e, key_state, key_press, m_state, m_press);
         end
      end
      // last transition sampled on edge 11, so the press lands on edge 16
      n_tests++;
      if (n_press != 1 || at_edge != 16) begin
         n_fail++;
         $display("FAIL alternate_pulse: %0d pulses at edge %0d, required 1 at edge 16", n_press, at_edge);
      end
   endtask

   task automatic test_release_both();
      logic [N-1:0] exp_state, exp_rel;
      apply_reset();
      key = 2'b00;
      for (int e = 1; e <= 8; e++) tick();
      n_tests++;
      if (key_state !== 2'b00) begin
         n_fail++;
         $display("FAIL both_pressed: state=%b, required 00", key_state);
      end
      key = 2'b11;
      for (int e = 1; e <= 7; e++) begin
         tick();
         exp_state = (e >= 6) ? 2'b11 : 2'b00;
         exp_rel   = (e == 6) ? 2'b11 : 2'b00;
         n_tests++;
         if (key_state !== exp_state || key_release !== exp_rel || key_press !== 2'b00) begin
            n_fail++;
            $display("FAIL release_both edge %0d: state=%b release=%b press=%b, required %b/%b/00", e, key_state, key_release, key_press, exp_state, exp_rel);
         end
      end
   endtask

   task automatic test_reset_midcount();
      logic [N-1:0] exp_state, exp_press;
      apply_reset();
      key = 2'b01;
      for (int e = 1; e <= 8; e++) tick();
      key = 2'b11;
      for (int e = 1; e <= 8; e++) tick();
      key = 2'b01;
      for (int e = 1; e <= 4; e++) tick();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (key_state !== 2'b11 || key_press !== 2'b00 || key_release !== 2'b00) begin
         n_fail++;
         $display("FAIL midcount_reset: state=%b press=%b release=%b, required 11/00/00", key_state, key_press, key_release);
      end
`ifdef KEY_TOGGLE_EN
      n_tests++;
      if (key_toggle !== 2'b00) begin
         n_fail++;
         $display("FAIL midcount_toggle_reset: toggle=%b, required 00", key_toggle);
      end
`endif
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         tick();
         exp_state = (e >= 6) ? 2'b01 : 2'b11;
         exp_press = (e == 6) ? 2'b10 : 2'b00;
         n_tests++;
         if (key_state !== exp_state || key_press !== exp_press) begin
            n_fail++;
            $display("FAIL midcount_press edge %0d: state=%b press=%b, required %b/%b", e, key_state, key_press, exp_state, exp_press);
         end
      end
`ifdef KEY_TOGGLE_EN
      n_tests++;
      if (key_toggle !== 2'b10) begin
         n_fail++;
         $display("FAIL toggle_first: toggle=%b, required 10", key_toggle);
      end
      key = 2'b11;
      for (int e = 1; e <= 8; e++) tick();
      n_tests++;
      if (key_toggle !== 2'b10) begin
         n_fail++;
         $display("FAIL toggle_release: toggle=%b, required 10", key_toggle);
      end
      key = 2'b01;
      for (int e = 1; e <= 8; e++) tick();
      n_tests++;
      if (key_toggle !== 2'b00) begin
         n_fail++;
         $display("FAIL toggle_second: toggle=%b, required 00", key_toggle);
      end
`endif
   endtask

   task automatic test_random();
      apply_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 5) == 0) key[i] = ~key[i];
         tick();
         n_tests++;
         if (key_state !== m_state || key_press !== m_press || key_release !== m_release ||
             (key_press & key_release) !== 2'b00) begin
            n_fail++;
            $display("FAIL random cycle %0d: state=%b press=%b release=%b, required %b/%b/%b", c, key_state, key_press, key_release, m_state, m_press, m_release);
         end
`ifdef KEY_TOGGLE_EN
         n_tests++;
         if (key_toggle !== m_toggle) begin
            n_fail++;
            $display("FAIL random_toggle cycle %0d: toggle=%b, required %b", c, key_toggle, m_toggle);
         end
`endif
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_press();
      test_bounce();
      test_alternate();
      test_release_both();
      test_reset_midcount();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
